// File: rtl/control_fsm_if.sv
// Bundle between the decoder/datapath side (master) and the multicycle control unit (slave).
// i_bit is the decoder immediate bit; the control unit forwards it to alu_src only in EXEC.
interface control_fsm_if #(
   parameter int unsigned CNT_W = 16
);
   // decoder fields and ALU status toward the control unit
   logic             start;
   logic [3:0]       cond;
   logic [1:0]       op;
   logic [3:0]       opcode;
   logic             s_bit;
   logic             u_bit;
   logic             l_bit;
   logic             i_bit;
   logic [3:0]       alu_flags;

   // datapath strobes, selects and status from the control unit
   logic             ir_we;
   logic             pc_we;
   logic             pc_src;
   logic             reg_we;
   logic             mem_we;
   logic             mem_to_reg;
   logic             alu_src;
   logic [2:0]       alu_ctrl;
   logic [3:0]       flags;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired;
   logic             illegal;

   modport master (
      output start, cond, op, opcode, s_bit, u_bit, l_bit, i_bit, alu_flags,
      input  ir_we, pc_we, pc_src, reg_we, mem_we, mem_to_reg, alu_src, alu_ctrl,
             flags, state, retired, illegal
   );

   modport slave (
      input  start, cond, op, opcode, s_bit, u_bit, l_bit, i_bit, alu_flags,
      output ir_we, pc_we, pc_src, reg_we, mem_we, mem_to_reg, alu_src, alu_ctrl,
             flags, state, retired, illegal
   );
endinterface

// File: rtl/control_fsm.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// strobes and selects, holds NZCV and evaluates condition codes.
// Strobes and selects are decoded from the state register and the live decoder
// fields so that DECODE can redirect the PC in the same cycle; flags, retired and
// illegal are registers.
module control_fsm #(
   parameter int unsigned CNT_W = 16
) (
   input logic         clk,
   input logic         rst,
   control_fsm_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_ORR  = 3'b011;
   localparam logic [2:0] ALU_PASS = 3'b100;

   state_e           state_q, state_d;
   logic [3:0]       flags_q, flags_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic       cond_ok;
   logic       dp_ok;
   logic       is_test;
   logic [2:0] dp_ctrl;
   logic [2:0] mem_ctrl;

   logic       ir_we_c, pc_we_c, pc_src_c, reg_we_c, mem_we_c, mem_to_reg_c, alu_src_c;
   logic [2:0] alu_ctrl_c;

   // Condition-code check against the architectural flags
   always_comb begin
      logic n, z, c, v;
      {n, z, c, v} = flags_q;
      cond_ok = 1'b0;
      case (bus.cond)
         4'b0000: cond_ok = z;
         4'b0001: cond_ok = !z;
         4'b0010: cond_ok = c;
         4'b0011: cond_ok = !c;
         4'b0100: cond_ok = n;
         4'b0101: cond_ok = !n;
         4'b0110: cond_ok = v;
         4'b0111: cond_ok = !v;
         4'b1000: cond_ok = c & !z;
         4'b1001: cond_ok = !c | z;
         4'b1010: cond_ok = (n == v);
         4'b1011: cond_ok = (n != v);
         4'b1100: cond_ok = !z & (n == v);
         4'b1101: cond_ok = z | (n != v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // Data-processing opcode decode: ALU operation, support and compare-only flag
   always_comb begin
      dp_ctrl = ALU_ADD;
      dp_ok   = 1'b1;
      is_test = 1'b0;
      case (bus.opcode)
         4'b0000: dp_ctrl = ALU_AND;
         4'b0010: dp_ctrl = ALU_SUB;
         4'b0100: dp_ctrl = ALU_ADD;
         4'b1000: begin dp_ctrl = ALU_AND; is_test = 1'b1; end
         4'b1010: begin dp_ctrl = ALU_SUB; is_test = 1'b1; end
         4'b1100: dp_ctrl = ALU_ORR;
         4'b1101: dp_ctrl = ALU_PASS;
         default: dp_ok = 1'b0;
      endcase
      mem_ctrl = bus.u_bit ? ALU_ADD : ALU_SUB;
   end

   // Next-state, strobe decode and register updates
   always_comb begin
      state_d      = state_q;
      flags_d      = flags_q;
      illegal_d    = illegal_q;
      ir_we_c      = 1'b0;
      pc_we_c      = 1'b0;
      pc_src_c     = 1'b0;
      reg_we_c     = 1'b0;
      mem_we_c     = 1'b0;
      mem_to_reg_c = 1'b0;
      alu_src_c    = 1'b0;
      alu_ctrl_c   = ALU_ADD;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (!bus.start) begin
               state_d = S_IDLE;
            end else begin
               ir_we_c = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_FETCH;
            if (!cond_ok) begin
               pc_we_c = 1'b1;
            end else if (bus.op == OP_BR) begin
               pc_we_c  = 1'b1;
               pc_src_c = 1'b1;
            end else if (bus.op == OP_UND || (bus.op == OP_DP && !dp_ok)) begin
               illegal_d = 1'b1;
               pc_we_c   = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (bus.op == OP_MEM) begin
               alu_src_c  = 1'b1;
               alu_ctrl_c = mem_ctrl;
               state_d    = S_MEM;
            end else begin
               alu_src_c  = bus.i_bit;
               alu_ctrl_c = dp_ctrl;
               if (bus.s_bit || is_test) flags_d = bus.alu_flags;
               if (is_test) begin
                  pc_we_c = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_MEM: begin
            alu_src_c  = 1'b1;
            alu_ctrl_c = mem_ctrl;
            if (bus.l_bit) begin
               state_d = S_WB;
            end else begin
               mem_we_c = 1'b1;
               pc_we_c  = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_WB: begin
            reg_we_c     = 1'b1;
            pc_we_c      = 1'b1;
            mem_to_reg_c = (bus.op == OP_MEM) && bus.l_bit;
            state_d      = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
      retired_d = pc_we_c ? retired_q + CNT_W'(1) : retired_q;
   end

   // State, flags, sticky illegal and retired-instruction counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         flags_q   <= 4'b0000;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   assign bus.ir_we      = ir_we_c;
   assign bus.pc_we      = pc_we_c;
   assign bus.pc_src     = pc_src_c;
   assign bus.reg_we     = reg_we_c;
   assign bus.mem_we     = mem_we_c;
   assign bus.mem_to_reg = mem_to_reg_c;
   assign bus.alu_src    = alu_src_c;
   assign bus.alu_ctrl   = alu_ctrl_c;
   assign bus.flags      = flags_q;
   assign bus.state      = state_q;
   assign bus.retired    = retired_q;
   assign bus.illegal    = illegal_q;

endmodule
